l1_mem_responder: RTL and testbench
===================================

L1_MEM_RESPONDER -- requirements
Module: l1_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH_LOG2, default 10, log2 of memory depth in 32-bit words.
REQ-002 SHALL have ports clk (in, 1, clock) and rstn (in, 1, reset); reset rstn is synchronous, active-low; clock clk.
REQ-003 SHALL have read-address ports: s_axi_ARVALID in 1, s_axi_ARREADY out 1, s_axi_ARADDR in 32 (byte address), s_axi_ARLEN in 8 (beats-1), s_axi_ARSIZE in 3 (size code).
REQ-004 SHALL have read-data ports: s_axi_RVALID out 1, s_axi_RREADY in 1, s_axi_RDATA out 32, s_axi_RLAST out 1, s_axi_RID out 1, s_axi_RRESP out 2.
REQ-005 SHALL have write-address ports: s_axi_AWVALID in 1, s_axi_AWREADY out 1, s_axi_AWADDR in 32, s_axi_AWLEN in 8, s_axi_AWSIZE in 3.
REQ-006 SHALL have write-data ports: s_axi_WVALID in 1, s_axi_WREADY out 1, s_axi_WDATA in 32, s_axi_WSTRB in 4 (byte enables), s_axi_WLAST in 1.
REQ-007 SHALL have write-response ports: s_axi_BVALID out 1, s_axi_BREADY in 1, s_axi_BRESP out 2, s_axi_BID out 1.

Function
REQ-008 SHALL serve the core's L1 master port as a slave backed by 2^MEM_DEPTH_LOG2 words of local memory.
REQ-009 SHALL run independent read and write FSMs; read FSM states R_IDLE, R_FETCH, R_SEND; write FSM states W_IDLE, W_DATA, W_RESP.
REQ-010 SHALL assert ARREADY only in R_IDLE; an AR handshake latches word address ARADDR[MEM_DEPTH_LOG2+1:2] and ARLEN, then goes to R_FETCH.
REQ-011 SHALL issue the memory read in R_FETCH and enter R_SEND next cycle with RVALID=1; first beat appears 2 cycles after the AR handshake.
REQ-012 SHALL hold RVALID, RDATA, RLAST, RRESP stable until RREADY; on each accepted beat, increment address (INCR) and present the next beat the following cycle: sustained 1 beat/cycle with RREADY held high.
REQ-013 SHALL assert RLAST only on beat ARLEN+1; after it is accepted, return to R_IDLE; ARREADY rises the next cycle.
REQ-014 SHALL treat ARSIZE/AWSIZE as 3'b010 whatever the value; RID=0 and BID=0 always.
REQ-015 SHALL assert AWREADY only in W_IDLE; AW handshake latches word address and AWLEN, then goes to W_DATA.
REQ-016 SHALL assert WREADY only in W_DATA; each accepted beat writes the bytes enabled by WSTRB, increments the address, and decrements the beat count.
REQ-017 SHALL leave W_DATA after beat AWLEN+1 whatever the WLAST value; WLAST is not used for termination.
REQ-018 SHALL hold BVALID in W_RESP until BREADY, then return to W_IDLE.
REQ-019 SHALL make memory read-first: a read and a write to the same word in the same cycle returns the old data.
REQ-020 SHALL keep a write in W_DATA visible to any read issued on a later cycle.
REQ-021 SHALL wrap addresses modulo the memory depth when bounds checking is compiled out.

Reset
REQ-022 SHALL reset outputs to ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RDATA=0, AWREADY=0, WREADY=0, BVALID=0, BRESP=0; FSMs reset to R_IDLE and W_IDLE; READY outputs rise the first cycle after reset releases.
REQ-023 SHALL abandon any in-flight burst on reset with no further beats or responses; memory contents are not reset.

Configuration
REQ-024 SHALL, with L1_RESP_BOUNDS_CHECK_EN defined, give RRESP=2'b10 and RDATA=0 for any read beat whose full word address (ARADDR>>2 plus beat index) is at or above 2^MEM_DEPTH_LOG2, drop out-of-range write beats, and return BRESP=2'b10 if any beat of the burst was dropped.
REQ-025 SHALL, without L1_RESP_BOUNDS_CHECK_EN, ignore upper address bits (aliasing) and always return RRESP=BRESP=2'b00.

Structure
REQ-026 SHALL define AXI_RESP_OKAY (2'b00), AXI_RESP_SLVERR (2'b10) and the read/write FSM state typedefs in the shared chronos package.
REQ-027 SHALL put storage in one sub-module, l1_bram: simple dual-port, one read port and one byte-enabled write port, synchronous read-first, depth 2^MEM_DEPTH_LOG2.

Verification
REQ-028 SHALL cover: AW 0x0 AWLEN 9, data 0..9 -> BRESP 0; then AR 0x0 ARLEN 9 -> 10 beats 0..9, RLAST only on the 10th, 1 beat/cycle.
REQ-029 SHALL cover: same read with RREADY toggling every cycle -> exactly 10 beats, none duplicated or dropped, RDATA stable while stalled.
REQ-030 SHALL cover: word 0x8 = 0xFFFFFFFF, then write 0x12345678 with WSTRB 4'b0011 -> read 0xFFFF5678.
REQ-031 SHALL cover: MEM_DEPTH_LOG2=4, AR 0x3C ARLEN 1 -> with macro, beat0 OKAY, beat1 SLVERR data 0; without macro, beat1 = word 0.
REQ-032 SHALL cover: rstn low during beat 3 of a 10-beat read -> RVALID=0 next cycle, ARREADY=1 the cycle after release, new read returns correct data.

Source files
------------

// File: rtl/chronos_pkg.sv
// Shared definitions for the chronos L1 memory path: AXI field widths,
// response codes and the read/write FSM state encodings.
package chronos_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
    localparam int unsigned AXI_LEN_W  = 8;
    localparam int unsigned AXI_RESP_W = 2;

    localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_SEND  = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/l1_bram.sv
// Simple dual-port word memory: one synchronous read port, one byte-enabled
// write port, read-first when both hit the same word in the same cycle.
// Ports:
//   clk, rstn        - clock, synchronous active-low reset (read register only)
//   rd_en/rd_addr    - read request; data lands in rd_data on the next edge
//   rd_zero          - return zero instead of memory contents for this read
//   wr_en/wr_addr    - write request
//   wr_be/wr_data    - byte enables and write data
module l1_bram
    import chronos_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rd_en,
    input  logic                  rd_zero,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [AXI_DATA_W-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [AXI_STRB_W-1:0] wr_be,
    input  logic [AXI_DATA_W-1:0] wr_data
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [AXI_DATA_W-1:0] mem [DEPTH];

    // Byte-enabled write; contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < AXI_STRB_W; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Registered read; sampling mem here before the write lands gives read-first.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/l1_mem_responder.sv
// AXI slave answering the core's L1 master port from 2^MEM_DEPTH_LOG2 words
// of local memory, with independent INCR read and write burst engines.
// Define L1_RESP_BOUNDS_CHECK_EN to return SLVERR for beats beyond the memory
// instead of aliasing the upper address bits.
// Ports:
//   clk, rstn      - clock, synchronous active-low reset
//   s_axi_AR*      - read address channel (ARSIZE ignored, 32-bit beats)
//   s_axi_R*       - read data channel (RID always 0)
//   s_axi_AW*      - write address channel (AWSIZE ignored)
//   s_axi_W*       - write data channel (WLAST ignored, AWLEN ends the burst)
//   s_axi_B*       - write response channel (BID always 0)
module l1_mem_responder
    import chronos_pkg::*;
#(
    parameter int unsigned MEM_DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_axi_ARVALID,
    output logic                  s_axi_ARREADY,
    input  logic [AXI_ADDR_W-1:0] s_axi_ARADDR,
    input  logic [AXI_LEN_W-1:0]  s_axi_ARLEN,
    input  logic [2:0]            s_axi_ARSIZE,
    output logic                  s_axi_RVALID,
    input  logic                  s_axi_RREADY,
    output logic [AXI_DATA_W-1:0] s_axi_RDATA,
    output logic                  s_axi_RLAST,
    output logic                  s_axi_RID,
    output logic [AXI_RESP_W-1:0] s_axi_RRESP,
    input  logic                  s_axi_AWVALID,
    output logic                  s_axi_AWREADY,
    input  logic [AXI_ADDR_W-1:0] s_axi_AWADDR,
    input  logic [AXI_LEN_W-1:0]  s_axi_AWLEN,
    input  logic [2:0]            s_axi_AWSIZE,
    input  logic                  s_axi_WVALID,
    output logic                  s_axi_WREADY,
    input  logic [AXI_DATA_W-1:0] s_axi_WDATA,
    input  logic [AXI_STRB_W-1:0] s_axi_WSTRB,
    input  logic                  s_axi_WLAST,
    output logic                  s_axi_BVALID,
    input  logic                  s_axi_BREADY,
    output logic [AXI_RESP_W-1:0] s_axi_BRESP,
    output logic                  s_axi_BID
);

    // Full word address plus one carry bit so a burst running off the top is still seen.
    localparam int unsigned WADDR_W = AXI_ADDR_W - 1;

`ifdef L1_RESP_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    function automatic logic out_of_range(input logic [WADDR_W-1:0] a);
        return BOUNDS_EN && ((a >> MEM_DEPTH_LOG2) != '0);
    endfunction

    // ---------------- read engine ----------------
    rd_state_e               r_state_q, r_state_d;
    logic [WADDR_W-1:0]      r_addr_q, r_addr_d, r_addr_inc_c;
    logic [AXI_LEN_W-1:0]    r_cnt_q, r_cnt_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic                    rlast_q, rlast_d;
    logic [AXI_RESP_W-1:0]   rresp_q, rresp_d;
    logic                    rd_en_c, rd_zero_c;
    logic [MEM_DEPTH_LOG2-1:0] rd_addr_c;

    assign r_addr_inc_c = r_addr_q + WADDR_W'(1);

    // Read state and registered read-channel outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= AXI_RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_cnt_q   <= r_cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
        end
    end

    // Read next-state: the next beat is fetched in the cycle the current one is accepted.
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_cnt_d   = r_cnt_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rd_en_c   = 1'b0;
        rd_zero_c = 1'b0;
        rd_addr_c = r_addr_q[MEM_DEPTH_LOG2-1:0];
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_ARVALID && arready_q) begin
                    r_addr_d  = {1'b0, s_axi_ARADDR[AXI_ADDR_W-1:2]};
                    r_cnt_d   = s_axi_ARLEN;
                    r_state_d = R_FETCH;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_FETCH: begin
                rd_en_c   = 1'b1;
                rd_zero_c = out_of_range(r_addr_q);
                rvalid_d  = 1'b1;
                rlast_d   = (r_cnt_q == '0);
                rresp_d   = rd_zero_c ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                r_state_d = R_SEND;
            end
            R_SEND: begin
                if (s_axi_RREADY) begin
                    if (r_cnt_q == '0) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rresp_d   = AXI_RESP_OKAY;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        rd_en_c   = 1'b1;
                        rd_addr_c = r_addr_inc_c[MEM_DEPTH_LOG2-1:0];
                        rd_zero_c = out_of_range(r_addr_inc_c);
                        r_addr_d  = r_addr_inc_c;
                        r_cnt_d   = r_cnt_q - AXI_LEN_W'(1);
                        rlast_d   = (r_cnt_q == AXI_LEN_W'(1));
                        rresp_d   = rd_zero_c ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ---------------- write engine ----------------
    wr_state_e               w_state_q, w_state_d;
    logic [WADDR_W-1:0]      w_addr_q, w_addr_d;
    logic [AXI_LEN_W-1:0]    w_cnt_q, w_cnt_d;
    logic                    w_err_q, w_err_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [AXI_RESP_W-1:0]   bresp_q, bresp_d;
    logic                    wr_en_c, w_oor_c;

    assign w_oor_c = out_of_range(w_addr_q);

    // Write state and registered write-channel outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Write next-state: beat count from AWLEN ends the burst, dropped beats flag SLVERR.
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_en_c   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_AWVALID && awready_q) begin
                    w_addr_d  = {1'b0, s_axi_AWADDR[AXI_ADDR_W-1:2]};
                    w_cnt_d   = s_axi_AWLEN;
                    w_err_d   = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end else begin
                    awready_d = 1'b1;
                end
            end
            W_DATA: begin
                if (s_axi_WVALID && wready_q) begin
                    wr_en_c  = !w_oor_c;
                    w_err_d  = w_err_q | w_oor_c;
                    w_addr_d = w_addr_q + WADDR_W'(1);
                    if (w_cnt_q == '0) begin
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_err_q || w_oor_c) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d  = w_cnt_q - AXI_LEN_W'(1);
                        wready_d = 1'b1;
                    end
                end else begin
                    wready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (s_axi_BREADY) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = AXI_RESP_OKAY;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    l1_bram #(
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_bram (
        .clk     (clk),
        .rstn    (rstn),
        .rd_en   (rd_en_c),
        .rd_zero (rd_zero_c),
        .rd_addr (rd_addr_c),
        .rd_data (s_axi_RDATA),
        .wr_en   (wr_en_c),
        .wr_addr (w_addr_q[MEM_DEPTH_LOG2-1:0]),
        .wr_be   (s_axi_WSTRB),
        .wr_data (s_axi_WDATA)
    );

    assign s_axi_ARREADY = arready_q;
    assign s_axi_RVALID  = rvalid_q;
    assign s_axi_RLAST   = rlast_q;
    assign s_axi_RRESP   = rresp_q;
    assign s_axi_RID     = 1'b0;
    assign s_axi_AWREADY = awready_q;
    assign s_axi_WREADY  = wready_q;
    assign s_axi_BVALID  = bvalid_q;
    assign s_axi_BRESP   = bresp_q;
    assign s_axi_BID     = 1'b0;

    // Byte-lane address bits, size codes and WLAST carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_ARADDR[1:0], s_axi_AWADDR[1:0],
                             s_axi_ARSIZE, s_axi_AWSIZE, s_axi_WLAST};

endmodule

// File: tb/tb_l1_mem_responder.sv
// Directed bench for l1_mem_responder at MEM_DEPTH_LOG2=4 (16 words).
module tb_l1_mem_responder;

    localparam int unsigned DEPTH_LOG2 = 4;
`ifdef L1_RESP_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_axi_ARVALID, s_axi_ARREADY;
    logic [31:0] s_axi_ARADDR;
    logic [7:0]  s_axi_ARLEN;
    logic [2:0]  s_axi_ARSIZE;
    logic        s_axi_RVALID, s_axi_RREADY;
    logic [31:0] s_axi_RDATA;
    logic        s_axi_RLAST, s_axi_RID;
    logic [1:0]  s_axi_RRESP;
    logic        s_axi_AWVALID, s_axi_AWREADY;
    logic [31:0] s_axi_AWADDR;
    logic [7:0]  s_axi_AWLEN;
    logic [2:0]  s_axi_AWSIZE;
    logic        s_axi_WVALID, s_axi_WREADY;
    logic [31:0] s_axi_WDATA;
    logic [3:0]  s_axi_WSTRB;
    logic        s_axi_WLAST;
    logic        s_axi_BVALID, s_axi_BREADY;
    logic [1:0]  s_axi_BRESP;
    logic        s_axi_BID;

    int errors = 0;
    int checks = 0;

    logic [31:0] wd    [16];
    logic [31:0] exp_d [16];
    logic [1:0]  exp_r [16];

    l1_mem_responder #(.MEM_DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axi_ARVALID (s_axi_ARVALID),
        .s_axi_ARREADY (s_axi_ARREADY),
        .s_axi_ARADDR  (s_axi_ARADDR),
        .s_axi_ARLEN   (s_axi_ARLEN),
        .s_axi_ARSIZE  (s_axi_ARSIZE),
        .s_axi_RVALID  (s_axi_RVALID),
        .s_axi_RREADY  (s_axi_RREADY),
        .s_axi_RDATA   (s_axi_RDATA),
        .s_axi_RLAST   (s_axi_RLAST),
        .s_axi_RID     (s_axi_RID),
        .s_axi_RRESP   (s_axi_RRESP),
        .s_axi_AWVALID (s_axi_AWVALID),
        .s_axi_AWREADY (s_axi_AWREADY),
        .s_axi_AWADDR  (s_axi_AWADDR),
        .s_axi_AWLEN   (s_axi_AWLEN),
        .s_axi_AWSIZE  (s_axi_AWSIZE),
        .s_axi_WVALID  (s_axi_WVALID),
        .s_axi_WREADY  (s_axi_WREADY),
        .s_axi_WDATA   (s_axi_WDATA),
        .s_axi_WSTRB   (s_axi_WSTRB),
        .s_axi_WLAST   (s_axi_WLAST),
        .s_axi_BVALID  (s_axi_BVALID),
        .s_axi_BREADY  (s_axi_BREADY),
        .s_axi_BRESP   (s_axi_BRESP),
        .s_axi_BID     (s_axi_BID)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len, input logic [3:0] strb,
                               input logic [1:0] exp_bresp, input string name);
        int guard;
        s_axi_AWVALID = 1'b1;
        s_axi_AWADDR  = addr;
        s_axi_AWLEN   = 8'(len);
        s_axi_AWSIZE  = 3'b010;
        guard = 0;
        while (!s_axi_AWREADY && guard < 50) begin tick(); guard++; end
        if (!s_axi_AWREADY) begin
            checks++; errors++;
            $display("FAIL %s_aw_timeout: AWREADY=%b expected 1", name, s_axi_AWREADY);
            s_axi_AWVALID = 1'b0;
            return;
        end
        tick();
        s_axi_AWVALID = 1'b0;
        for (int b = 0; b <= len; b++) begin
            s_axi_WVALID = 1'b1;
            s_axi_WDATA  = wd[b];
            s_axi_WSTRB  = strb;
            s_axi_WLAST  = (b == len);
            guard = 0;
            while (!s_axi_WREADY && guard < 50) begin tick(); guard++; end
            if (!s_axi_WREADY) begin
                checks++; errors++;
                $display("FAIL %s_w_timeout: WREADY=%b expected 1 at beat %0d", name, s_axi_WREADY, b);
                s_axi_WVALID = 1'b0;
                return;
            end
            tick();
        end
        s_axi_WVALID = 1'b0;
        s_axi_WLAST  = 1'b0;
        s_axi_BREADY = 1'b1;
        guard = 0;
        while (!s_axi_BVALID && guard < 50) begin tick(); guard++; end
        checks++;
        if (s_axi_BVALID !== 1'b1 || s_axi_BRESP !== exp_bresp || s_axi_BID !== 1'b0) begin
            errors++;
            $display("FAIL %s_bresp: BVALID=%b BRESP=%b BID=%b expected 1 %b 0",
                     name, s_axi_BVALID, s_axi_BRESP, s_axi_BID, exp_bresp);
        end
        tick();
        s_axi_BREADY = 1'b0;
        checks++;
        if ({s_axi_BVALID, s_axi_AWREADY} !== 2'b01) begin
            errors++;
            $display("FAIL %s_b_done: BVALID,AWREADY=%b expected 01", name, {s_axi_BVALID, s_axi_AWREADY});
        end
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len, input bit toggle, input string name);
        int guard, beat, cyc;
        bit stalled;
        logic [31:0] held;
        beat = 0; cyc = 0; stalled = 1'b0; held = '0;
        s_axi_ARVALID = 1'b1;
        s_axi_ARADDR  = addr;
        s_axi_ARLEN   = 8'(len);
        s_axi_ARSIZE  = 3'b000;
        s_axi_RREADY  = 1'b0;
        guard = 0;
        while (!s_axi_ARREADY && guard < 50) begin tick(); guard++; end
        if (!s_axi_ARREADY) begin
            checks++; errors++;
            $display("FAIL %s_ar_timeout: ARREADY=%b expected 1", name, s_axi_ARREADY);
            s_axi_ARVALID = 1'b0;
            return;
        end
        tick();
        s_axi_ARVALID = 1'b0;
        checks++;
        if (s_axi_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency: RVALID=%b one cycle after AR, expected 0", name, s_axi_RVALID);
        end
        tick();
        checks++;
        if (s_axi_RVALID !== 1'b1) begin
            errors++;
            $display("FAIL %s_first_beat: RVALID=%b two cycles after AR, expected 1", name, s_axi_RVALID);
        end
        while (beat <= len && cyc < 4 * (len + 1) + 8) begin
            s_axi_RREADY = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (s_axi_RVALID === 1'b1) begin
                if (stalled) begin
                    checks++;
                    if (s_axi_RDATA !== held) begin
                        errors++;
                        $display("FAIL %s_stall_hold: RDATA=%h expected %h", name, s_axi_RDATA, held);
                    end
                end
                if (s_axi_RREADY) begin
                    checks++;
                    if ({s_axi_RDATA, s_axi_RLAST, s_axi_RRESP, s_axi_RID} !==
                        {exp_d[beat], 1'(beat == len), exp_r[beat], 1'b0}) begin
                        errors++;
                        $display("FAIL %s_beat%0d: RDATA=%h RLAST=%b RRESP=%b RID=%b expected %h %b %b 0",
                                 name, beat, s_axi_RDATA, s_axi_RLAST, s_axi_RRESP, s_axi_RID,
                                 exp_d[beat], 1'(beat == len), exp_r[beat]);
                    end
                    beat++;
                    stalled = 1'b0;
                end else begin
                    held    = s_axi_RDATA;
                    stalled = 1'b1;
                end
            end else begin
                checks++; errors++;
                $display("FAIL %s_gap: RVALID=%b mid-burst at beat %0d, expected 1", name, s_axi_RVALID, beat);
            end
            tick();
            cyc++;
        end
        s_axi_RREADY = 1'b0;
        checks++;
        if (beat != len + 1) begin
            errors++;
            $display("FAIL %s_beats: accepted %0d beats expected %0d", name, beat, len + 1);
        end
        if (!toggle) begin
            checks++;
            if (cyc != len + 1) begin
                errors++;
                $display("FAIL %s_rate: burst took %0d cycles expected %0d", name, cyc, len + 1);
            end
        end
        checks++;
        if ({s_axi_RVALID, s_axi_ARREADY} !== 2'b01) begin
            errors++;
            $display("FAIL %s_end: RVALID,ARREADY=%b expected 01", name, {s_axi_RVALID, s_axi_ARREADY});
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        s_axi_ARVALID = 1'b0; s_axi_ARADDR = '0; s_axi_ARLEN = '0; s_axi_ARSIZE = '0;
        s_axi_RREADY  = 1'b0;
        s_axi_AWVALID = 1'b0; s_axi_AWADDR = '0; s_axi_AWLEN = '0; s_axi_AWSIZE = '0;
        s_axi_WVALID  = 1'b0; s_axi_WDATA = '0; s_axi_WSTRB = '0; s_axi_WLAST = 1'b0;
        s_axi_BREADY  = 1'b0;
        repeat (3) tick();
        checks++;
        if ({s_axi_ARREADY, s_axi_RVALID, s_axi_RLAST, s_axi_RRESP, s_axi_AWREADY,
             s_axi_WREADY, s_axi_BVALID, s_axi_BRESP} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl: AR,RV,RL,RRESP,AW,W,BV,BRESP=%b expected 0",
                     {s_axi_ARREADY, s_axi_RVALID, s_axi_RLAST, s_axi_RRESP, s_axi_AWREADY,
                      s_axi_WREADY, s_axi_BVALID, s_axi_BRESP});
        end
        checks++;
        if (s_axi_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: RDATA=%h expected 00000000", s_axi_RDATA);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if ({s_axi_ARREADY, s_axi_AWREADY, s_axi_WREADY, s_axi_RVALID, s_axi_BVALID} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_release: AR,AW,W,RV,BV=%b expected 11000",
                     {s_axi_ARREADY, s_axi_AWREADY, s_axi_WREADY, s_axi_RVALID, s_axi_BVALID});
        end
    endtask

    task automatic test_burst();
        for (int i = 0; i < 10; i++) begin
            wd[i] = 32'(i);
            exp_d[i] = 32'(i);
            exp_r[i] = 2'b00;
        end
        write_burst(32'h0, 9, 4'hF, 2'b00, "burst_wr");
        read_burst(32'h0, 9, 1'b0, "burst_rd");
    endtask

    task automatic test_rready_toggle();
        for (int i = 0; i < 10; i++) begin
            exp_d[i] = 32'(i);
            exp_r[i] = 2'b00;
        end
        read_burst(32'h0, 9, 1'b1, "toggle_rd");
    endtask

    task automatic test_strobe();
        wd[0] = 32'hFFFF_FFFF;
        write_burst(32'h20, 0, 4'hF, 2'b00, "strb_fill");
        wd[0] = 32'h1234_5678;
        write_burst(32'h20, 0, 4'b0011, 2'b00, "strb_part");
        exp_d[0] = 32'hFFFF_5678;
        exp_r[0] = 2'b00;
        read_burst(32'h20, 0, 1'b0, "strb_rd");
    endtask

    task automatic test_reset_mid_read();
        s_axi_ARVALID = 1'b1;
        s_axi_ARADDR  = 32'h0;
        s_axi_ARLEN   = 8'd9;
        tick();
        s_axi_ARVALID = 1'b0;
        s_axi_RREADY  = 1'b1;
        tick();
        repeat (3) tick();
        checks++;
        if ({s_axi_RVALID, s_axi_RDATA} !== {1'b1, 32'd3}) begin
            errors++;
            $display("FAIL rst_mid_beat3: RVALID=%b RDATA=%h expected 1 00000003", s_axi_RVALID, s_axi_RDATA);
        end
        rstn = 1'b0;
        s_axi_RREADY = 1'b0;
        tick();
        checks++;
        if ({s_axi_RVALID, s_axi_RLAST, s_axi_ARREADY} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_abort: RVALID,RLAST,ARREADY=%b expected 000",
                     {s_axi_RVALID, s_axi_RLAST, s_axi_ARREADY});
        end
        tick();
        rstn = 1'b1;
        tick();
        checks++;
        if ({s_axi_ARREADY, s_axi_RVALID} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_release: ARREADY,RVALID=%b expected 10", {s_axi_ARREADY, s_axi_RVALID});
        end
        for (int i = 0; i < 4; i++) begin
            exp_d[i] = 32'(i + 1);
            exp_r[i] = 2'b00;
        end
        read_burst(32'h4, 3, 1'b0, "post_rst_rd");
    endtask

    task automatic test_bounds();
        wd[0] = 32'h1111_000F;
        wd[1] = 32'h2222_0000;
        write_burst(32'h3C, 1, 4'hF, BOUNDS ? 2'b10 : 2'b00, "oob_wr");
        exp_d[0] = 32'h1111_000F;
        exp_r[0] = 2'b00;
        exp_d[1] = BOUNDS ? 32'h0 : 32'h2222_0000;
        exp_r[1] = BOUNDS ? 2'b10 : 2'b00;
        read_burst(32'h3C, 1, 1'b0, "oob_rd");
        exp_d[0] = BOUNDS ? 32'h0 : 32'h2222_0000;
        exp_r[0] = 2'b00;
        read_burst(32'h0, 0, 1'b0, "alias_rd");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_burst();
        test_rready_toggle();
        test_strobe();
        test_reset_mid_read();
        test_bounds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
